fetch_pc_unit: RTL and testbench

- Instruction-fetch front end that owns the architectural PC register and consumes next-PC decisions: sequential, branch/jump target, exception entry, eret.
- Issues one outstanding instruction-memory request at a time and delivers {pc, instr, adel} to decode over a valid/ready handshake.
- Sits between the instruction-memory port and the IF/ID boundary.
- Implements MIPS delay-slot semantics for branch/jump redirects.

---
 rtl/fetch_pc_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC owner and single-outstanding instruction fetch front end
// Define FETCH_ADDR_CHECK_EN to enable fetch address checking (S_ERR path, if_adel).
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IM_LO     = 32'h0000_3000,
   parameter logic [31:0] IM_HI     = 32'h0000_6FFF
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_adel,
   input  logic        npc_valid,
   input  logic [31:0] npc_target,
   input  logic        exc_valid,
   input  logic        eret_valid,
   input  logic [31:0] epc
);

`ifdef FETCH_ADDR_CHECK_EN
   localparam logic CHECK_EN = 1'b1;
`else
   localparam logic CHECK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_REQ, S_OUT, S_ERR, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic        imem_req_q, imem_req_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_adel_q, if_adel_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_target_q, pend_target_d;

   logic handshake, outstanding, new_fetch, new_bad;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      imem_addr_d   = imem_addr_q;
      if_valid_d    = if_valid_q;
      if_pc_d       = if_pc_q;
      if_instr_d    = if_instr_q;
      if_adel_d     = if_adel_q;
      pend_d        = pend_q;
      pend_target_d = pend_target_q;
      handshake     = if_valid_q && if_ready;
      outstanding   = imem_req_q && !imem_ack;
      new_fetch     = 1'b0;

      if (npc_valid) begin
         pend_d        = 1'b1;
         pend_target_d = npc_target;
      end

      case (state_q)
         S_REQ: begin
            if (imem_req_q && imem_ack) begin
               if_pc_d    = fetch_pc_q;
               if_instr_d = imem_rdata;
               if_adel_d  = 1'b0;
               if_valid_d = 1'b1;
               state_d    = S_OUT;
            end
         end
         S_OUT: begin
            if (handshake) begin
               // The accepted instruction may itself be the delay slot of a same-cycle branch.
               if (npc_valid)   fetch_pc_d = npc_target;
               else if (pend_q) fetch_pc_d = pend_target_q;
               else             fetch_pc_d = if_pc_q + 32'd4;
               pend_d     = 1'b0;
               if_valid_d = 1'b0;
               new_fetch  = 1'b1;
            end
         end
         S_ERR: begin
            if_pc_d    = fetch_pc_q;
            if_instr_d = 32'd0;
            if_adel_d  = 1'b1;
            if_valid_d = 1'b1;
            state_d    = S_OUT;
         end
         S_DROP: begin
            if (imem_ack) new_fetch = 1'b1;
         end
         default: state_d = S_REQ;
      endcase

      if (exc_valid || eret_valid) begin
         fetch_pc_d = exc_valid ? EXC_ENTRY : epc;
         pend_d     = 1'b0;
         if_valid_d = 1'b0;
         if (outstanding) state_d = S_DROP;
         else             new_fetch = 1'b1;
      end

      new_bad = CHECK_EN && ((fetch_pc_d[1:0] != 2'b00) ||
                             (fetch_pc_d < IM_LO) || (fetch_pc_d > IM_HI));
      if (new_fetch) state_d = new_bad ? S_ERR : S_REQ;

      // The bus address must not move while a request waits for its ack.
      imem_req_d = (state_d == S_REQ) || (state_d == S_DROP);
      if (!outstanding) imem_addr_d = fetch_pc_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_REQ;
         fetch_pc_q    <= RESET_PC;
         imem_addr_q   <= RESET_PC;
         imem_req_q    <= 1'b0;
         if_valid_q    <= 1'b0;
         if_pc_q       <= 32'd0;
         if_instr_q    <= 32'd0;
         if_adel_q     <= 1'b0;
         pend_q        <= 1'b0;
         pend_target_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         imem_addr_q   <= imem_addr_d;
         imem_req_q    <= imem_req_d;
         if_valid_q    <= if_valid_d;
         if_pc_q       <= if_pc_d;
         if_instr_q    <= if_instr_d;
         if_adel_q     <= if_adel_d;
         pend_q        <= pend_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = CHECK_EN ? imem_addr_q : {imem_addr_q[31:2], 2'b00};
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_instr  = if_instr_q;
   assign if_adel   = CHECK_EN && if_adel_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - randomized bench for fetch_pc_unit against a transaction-level PC model
// Honours FETCH_ADDR_CHECK_EN the same way as the design.
module tb_fetch_pc_unit;
   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] IM_LO     = 32'h0000_3000;
   localparam logic [31:0] IM_HI     = 32'h0000_6FFF;
`ifdef FETCH_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req, imem_ack, if_valid, if_ready, if_adel;
   logic        npc_valid, exc_valid, eret_valid;
   logic [31:0] imem_addr, imem_rdata, if_pc, if_instr, npc_target, epc;

   fetch_pc_unit dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_adel(if_adel),
      .npc_valid(npc_valid), .npc_target(npc_target),
      .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic bad(input logic [31:0] a);
      return CHK && ((a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI));
   endfunction

   function automatic logic [31:0] mask(input logic [31:0] a);
      return CHK ? a : {a[31:2], 2'b00};
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Model: next PC to be delivered, pending delay-slot redirect, squashed request.
   logic [31:0] exp_pc, pend_t, prev_addr, prev_pc, prev_instr;
   logic        pend, squashed, prev_flush, prev_hold, prev_wait;
   int          cyc = 0, last_hs = -1, age = 0, lat = 0, lat_lo = 0, lat_hi = 0, ready_pct = 100;
   bit          fullspeed = 1'b0;
   logic        npc_g = 1'b0, exc_g = 1'b0, eret_g = 1'b0;
   logic [31:0] npc_t_g = 32'd0, epc_g = 32'd0;
   logic [31:0] hs_log[$];
   logic [31:0] ack_log[$];

   task automatic step();
      logic ack, hs, fl;
      ack        = imem_req && (age >= lat);
      imem_ack   = ack;
      imem_rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      if_ready   = (int'($urandom_range(0, 99)) < ready_pct);
      npc_valid  = npc_g;
      npc_target = npc_t_g;
      exc_valid  = exc_g;
      eret_valid = eret_g;
      epc        = epc_g;
      hs = if_valid && if_ready;
      fl = exc_g || eret_g;

      if (prev_flush) check_eq("valid_after_flush", {31'd0, if_valid}, 32'd0);
      if (prev_hold) begin
         check_eq("hold_valid", {31'd0, if_valid}, 32'd1);
         check_eq("hold_pc", if_pc, prev_pc);
         check_eq("hold_instr", if_instr, prev_instr);
      end
      if (prev_wait) begin
         check_eq("req_held", {31'd0, imem_req}, 32'd1);
         check_eq("addr_held", imem_addr, prev_addr);
      end
      if (ack) begin
         if (squashed) squashed = 1'b0;
         else begin
            check_eq("imem_addr", imem_addr, mask(exp_pc));
            ack_log.push_back(imem_addr);
         end
      end
      if (hs) begin
         check_eq("if_pc", if_pc, exp_pc);
         check_eq("if_adel", {31'd0, if_adel}, {31'd0, bad(exp_pc)});
         check_eq("if_instr", if_instr, bad(exp_pc) ? 32'd0 : mem_word(mask(exp_pc)));
         if (fullspeed && last_hs >= 0) check_eq("hs_spacing", 32'(cyc - last_hs), 32'd2);
         last_hs = cyc;
         hs_log.push_back(if_pc);
         exp_pc = npc_g ? npc_t_g : (pend ? pend_t : exp_pc + 32'd4);
         pend   = 1'b0;
      end else if (npc_g) begin
         pend   = 1'b1;
         pend_t = npc_t_g;
      end
      if (fl) begin
         if (imem_req && !ack) squashed = 1'b1;
         exp_pc = exc_g ? EXC_ENTRY : epc_g;
         pend   = 1'b0;
      end

      prev_flush = fl;
      prev_hold  = if_valid && !if_ready && !fl;
      prev_pc    = if_pc;
      prev_instr = if_instr;
      prev_wait  = imem_req && !ack;
      prev_addr  = imem_addr;
      if (ack) begin
         age = 0;
         lat = int'($urandom_range(lat_lo, lat_hi));
      end else if (imem_req) age++;
      npc_g  = 1'b0;
      exc_g  = 1'b0;
      eret_g = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'd0; if_ready = 1'b0;
      npc_valid = 1'b0; npc_target = 32'd0; exc_valid = 1'b0; eret_valid = 1'b0; epc = 32'd0;
      npc_g = 1'b0; exc_g = 1'b0; eret_g = 1'b0;
      repeat (2) @(negedge clk);
      exp_pc = RESET_PC; pend = 1'b0; pend_t = 32'd0; squashed = 1'b0;
      prev_flush = 1'b0; prev_hold = 1'b0; prev_wait = 1'b0;
      last_hs = -1; age = 0;
      lat = int'($urandom_range(lat_lo, lat_hi));
   endtask

   function automatic logic [31:0] pick_epc();
      case ($urandom_range(0, 5))
         0: return 32'h0000_3002;
         1: return 32'h0000_7000;
         2: return 32'hFFFF_FFFC;
         default: return 32'h3000 + ($urandom_range(0, 4095) << 2);
      endcase
   endfunction

   initial begin
      int n, m, req_seen, r;
      logic found;

      // Reset state and zero-wait streaming
      lat_lo = 0; lat_hi = 0; ready_pct = 100; fullspeed = 1'b1;
      do_reset();
      check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check_eq("rst_if_pc", if_pc, 32'd0);
      check_eq("rst_if_instr", if_instr, 32'd0);
      check_eq("rst_if_adel", {31'd0, if_adel}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 40 && hs_log.size() < 3; i++) step();
      check_eq("a_hs_count", 32'(hs_log.size()), 32'd3);
      check_eq("a_addr0", ack_log.size() > 0 ? ack_log[0] : 32'd0, 32'h3000);
      check_eq("a_addr1", ack_log.size() > 1 ? ack_log[1] : 32'd0, 32'h3004);
      check_eq("a_addr2", ack_log.size() > 2 ? ack_log[2] : 32'd0, 32'h3008);

      // Branch at 0x3010 with its delay slot
      for (int i = 0; i < 40 && hs_log[$] != 32'h3010; i++) step();
      n = hs_log.size();
      npc_g = 1'b1; npc_t_g = 32'h3100;
      step();
      for (int i = 0; i < 40 && hs_log.size() < n + 2; i++) step();
      check_eq("b_delay_slot", hs_log.size() > n ? hs_log[n] : 32'd0, 32'h3014);
      check_eq("b_target", hs_log.size() > n + 1 ? hs_log[n + 1] : 32'd0, 32'h3100);

      // Exception while the 0x3020 request is waiting
      fullspeed = 1'b0; lat_lo = 3; lat_hi = 3; lat = 3;
      eret_g = 1'b1; epc_g = 32'h3020;
      step();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (imem_req && imem_addr == 32'h3020) found = 1'b1;
         else step();
      end
      check_eq("c_req_3020", {31'd0, found}, 32'd1);
      m = ack_log.size();
      exc_g = 1'b1;
      step();
      for (int i = 0; i < 10 && imem_req && imem_addr == 32'h3020; i++) begin
         check_eq("c_drop_valid", {31'd0, if_valid}, 32'd0);
         step();
      end
      for (int i = 0; i < 40 && ack_log.size() == m; i++) step();
      check_eq("c_after_drop", ack_log.size() > m ? ack_log[m] : 32'd0, EXC_ENTRY);

      // eret to a misaligned address
      lat_lo = 0; lat_hi = 0; lat = 0; ready_pct = 100;
      eret_g = 1'b1; epc_g = 32'h3002;
      step();
      n = hs_log.size(); m = ack_log.size(); req_seen = 0;
      for (int i = 0; i < 20 && hs_log.size() == n; i++) begin
         if (imem_req) req_seen++;
         step();
      end
      check_eq("d_delivered", 32'(hs_log.size()), 32'(n + 1));
`ifdef FETCH_ADDR_CHECK_EN
      check_eq("d_no_req", 32'(req_seen), 32'd0);
      check_eq("d_pc", hs_log.size() > n ? hs_log[n] : 32'd0, 32'h3002);
`else
      check_eq("d_addr", ack_log.size() > m ? ack_log[m] : 32'd0, 32'h3000);
`endif

      // Decode stall with 0x3004 held
      do_reset();
      reset = 1'b1;
      n = hs_log.size();
      for (int i = 0; i < 20 && hs_log.size() == n; i++) step();
      ready_pct = 0;
      for (int i = 0; i < 20 && !if_valid; i++) step();
      check_eq("e_valid", {31'd0, if_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check_eq("e_no_req", {31'd0, imem_req}, 32'd0);
         check_eq("e_pc", if_pc, 32'h3004);
         step();
      end
      ready_pct = 100;
      m = ack_log.size();
      for (int i = 0; i < 20 && ack_log.size() == m; i++) step();
      check_eq("e_next_addr", ack_log.size() > m ? ack_log[m] : 32'd0, 32'h3008);

      // Asynchronous reset in the middle of a request
      lat_lo = 3; lat_hi = 3;
      do_reset();
      reset = 1'b1;
      eret_g = 1'b1; epc_g = 32'h3040;
      step();
      for (int i = 0; i < 10 && !(imem_req && imem_addr == 32'h3040); i++) step();
      check_eq("f_req_3040", imem_addr, 32'h3040);
      step();
      #2 reset = 1'b0;
      #1;
      check_eq("f_async_req", {31'd0, imem_req}, 32'd0);
      check_eq("f_async_valid", {31'd0, if_valid}, 32'd0);
      do_reset();
      reset = 1'b1;
      m = ack_log.size();
      for (int i = 0; i < 20 && ack_log.size() == m; i++) step();
      check_eq("f_first_addr", ack_log.size() > m ? ack_log[m] : 32'd0, RESET_PC);

      // Random traffic: latency, stalls, branches after delivery, flushes
      lat_lo = 0; lat_hi = 3; ready_pct = 70;
      do_reset();
      reset = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (last_hs == cyc - 1 && $urandom_range(0, 99) < 30) begin
            npc_g = 1'b1;
            npc_t_g = 32'h3000 + ($urandom_range(0, 4095) << 2);
         end
         r = int'($urandom_range(0, 99));
         if (r < 3) exc_g = 1'b1;
         else if (r < 6) begin
            eret_g = 1'b1;
            epc_g = pick_epc();
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
